l2_request_queue: RTL and testbench

- Downstream stage of the L1 data cache.
- Captures each line-address request (26-bit line address plus 2-bit command) the L1 issues toward the next-level cache, and buffers it in a FIFO.
- Drains requests to the next-level cache over a valid/ready handshake.
- Keeps per-command issue statistics for the statistics module.

---
 rtl/l2_request_queue.sv | 137 +++++++++++++
 tb/tb_l2_request_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_queue.sv
// Request FIFO between the L1 data cache and the next-level cache, with per-command issue statistics.
// Optional write coalescing on the tail entry is built when L2Q_COALESCE_EN is defined.
module l2_request_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 26,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [1:0]                 in_cmd,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [1:0]                 out_cmd,
    output logic [ADDR_W-1:0]          out_addr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           rd_issued,
    output logic [CNT_W-1:0]           wr_issued,
    output logic [CNT_W-1:0]           dropped,
    output logic [CNT_W-1:0]           stall_cycles
`ifdef L2Q_COALESCE_EN
    ,
    output logic [CNT_W-1:0]           coalesced
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the partner's valid in the same cycle.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    logic [1:0]        mem_cmd  [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              legal;
    logic              accept;
    logic              dequeue;
    logic              drop;
    logic              merge;

    assign legal     = (in_cmd == CMD_READ) || (in_cmd == CMD_WRITE);
    assign in_ready  = (level != FULL_LVL);
    assign out_valid = (level != '0);
    assign dequeue   = out_valid && out_ready;
    assign out_cmd   = mem_cmd[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];

`ifdef L2Q_COALESCE_EN
    logic [PTR_W-1:0] tail_ptr;
    assign tail_ptr = wr_ptr - PTR_W'(1);
    // A tail that is also the head being popped this cycle cannot absorb a merge.
    assign merge = in_valid && (in_cmd == CMD_WRITE) && out_valid &&
                   !(dequeue && (level == LVL_W'(1))) &&
                   (mem_addr[tail_ptr] == in_addr);
`else
    assign merge = 1'b0;
`endif

    assign accept = in_valid && in_ready && legal && !merge;
    assign drop   = in_valid && legal && !in_ready && !merge;

    always_comb begin
        level_nxt = level;
        case ({accept, dequeue})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rd_issued    <= '0;
            wr_issued    <= '0;
            dropped      <= '0;
            stall_cycles <= '0;
`ifdef L2Q_COALESCE_EN
            coalesced    <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_cmd[i]  <= '0;
                mem_addr[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rd_issued    <= '0;
            wr_issued    <= '0;
            dropped      <= '0;
            stall_cycles <= '0;
`ifdef L2Q_COALESCE_EN
            coalesced    <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_cmd[i]  <= '0;
                mem_addr[i] <= '0;
            end
        end else begin
            level <= level_nxt;
            if (accept) begin
                mem_cmd[wr_ptr]  <= in_cmd;
                mem_addr[wr_ptr] <= in_addr;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
`ifdef L2Q_COALESCE_EN
            if (merge) begin
                mem_cmd[tail_ptr] <= CMD_WRITE;
                coalesced         <= coalesced + CNT_W'(1);
            end
`endif
            if (dequeue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (out_cmd == CMD_READ)
                    rd_issued <= rd_issued + CNT_W'(1);
                else if (out_cmd == CMD_WRITE)
                    wr_issued <= wr_issued + CNT_W'(1);
            end
            if (drop)
                dropped <= dropped + CNT_W'(1);
            if (out_valid && !out_ready)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_l2_request_queue.sv
// Directed bench for l2_request_queue: FIFO order, full/overflow, streaming, illegal commands,
// async reset mid-drain, and write coalescing when L2Q_COALESCE_EN is defined.
module tb_l2_request_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 26;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic [1:0]        in_cmd = 2'b00;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              in_ready;
    logic              out_valid;
    logic [1:0]        out_cmd;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready = 1'b0;
    logic [3:0]        level;
    logic [CNT_W-1:0]  rd_issued;
    logic [CNT_W-1:0]  wr_issued;
    logic [CNT_W-1:0]  dropped;
    logic [CNT_W-1:0]  stall_cycles;
`ifdef L2Q_COALESCE_EN
    logic [CNT_W-1:0]  coalesced;
`endif

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];

    l2_request_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_cmd       (in_cmd),
        .in_addr      (in_addr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_cmd      (out_cmd),
        .out_addr     (out_addr),
        .out_ready    (out_ready),
        .level        (level),
        .rd_issued    (rd_issued),
        .wr_issued    (wr_issued),
        .dropped      (dropped),
        .stall_cycles (stall_cycles)
`ifdef L2Q_COALESCE_EN
        ,
        .coalesced    (coalesced)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    // One edge, then settle 1 time unit past it for driving and sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic push(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr, input bit track);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_addr  = addr;
        step();
        in_valid = 1'b0;
        in_cmd   = 2'b00;
        if (track) exp_q.push_back({cmd, addr});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_q.delete();
    endtask

    // Drain everything the scoreboard expects, checking order; bounded by queue size.
    task automatic drain(input string tag);
        int n;
        logic [27:0] e;
        n = exp_q.size();
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_head"}, {4'h0, out_cmd, out_addr}, {4'h0, e});
            step();
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, 32'(level), 32'd0);
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_cmd", 32'(out_cmd), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_counters", rd_issued | wr_issued | dropped | stall_cycles, 32'd0);

        // Single READ, one-cycle latency, then stalls accumulate
        push(2'b01, 26'h0000123, 1'b1);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_cmd", 32'(out_cmd), 32'h1);
        check("t1_out_addr", 32'(out_addr), 32'h0000123);
        check("t1_level", 32'(level), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check("t1_stall", stall_cycles, 32'd3);
        drain("t1");
        check("t1_rd_issued", rd_issued, 32'd1);
        do_clear();
        check("clr_counters", rd_issued | wr_issued | dropped | stall_cycles, 32'd0);
        check("clr_level", 32'(level), 32'd0);

        // Fill to full, overflow one, drain in order
        for (int i = 0; i < DEPTH; i++)
            push((i % 2 == 0) ? 2'b01 : 2'b10, ADDR_W'(32'h100 + i), 1'b1);
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        check("t2_level_full", 32'(level), 32'd8);
        push(2'b10, 26'h00001FF, 1'b0);
        check("t2_dropped", dropped, 32'd1);
        check("t2_level_after_drop", 32'(level), 32'd8);
        drain("t2");
        check("t2_rd_issued", rd_issued, 32'd4);
        check("t2_wr_issued", wr_issued, 32'd4);
        do_clear();

        // Streaming at level 3: enqueue and dequeue together for 5 cycles
        for (int i = 0; i < 3; i++) push(2'b01, ADDR_W'(32'h200 + i), 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [27:0] e;
            e = exp_q.pop_front();
            check("t3_stream_head", {4'h0, out_cmd, out_addr}, {4'h0, e});
            in_valid = 1'b1;
            in_cmd   = 2'b10;
            in_addr  = ADDR_W'(32'h300 + i);
            exp_q.push_back({2'b10, in_addr});
            step();
            check("t3_level", 32'(level), 32'd3);
        end
        in_valid = 1'b0;
        drain("t3");
        do_clear();

        // Full queue: simultaneous enqueue attempt and dequeue
        for (int i = 0; i < DEPTH; i++) push(2'b01, ADDR_W'(32'h400 + i), 1'b1);
        in_valid  = 1'b1;
        in_cmd    = 2'b10;
        in_addr   = 26'h00004FF;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check("t4_level", 32'(level), 32'd7);
        check("t4_dropped", dropped, 32'd1);
        drain("t4");
        do_clear();

        // Illegal commands are ignored
        push(2'b01, 26'h0000500, 1'b1);
        push(2'b00, 26'h0000501, 1'b0);
        push(2'b11, 26'h0000502, 1'b0);
        check("t5_level", 32'(level), 32'd1);
        check("t5_dropped", dropped, 32'd0);
        check("t5_head", {4'h0, out_cmd, out_addr}, {4'h0, 2'b01, 26'h0000500});
        drain("t5");
        check("t5_issued", rd_issued + wr_issued, 32'd1);
        do_clear();

        // Async reset in the middle of a drain
        for (int i = 0; i < 4; i++) push(2'b10, ADDR_W'(32'h600 + i), 1'b1);
        out_ready = 1'b1;
        step();
        check("t6_wr_before_rst", wr_issued, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_counters", rd_issued | wr_issued | dropped | stall_cycles, 32'd0);
        out_ready = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        check("t6_in_ready", 32'(in_ready), 32'd1);

`ifdef L2Q_COALESCE_EN
        // Coalescing: repeated WRITE merges, READ upgraded by WRITE to same line
        do_clear();
        push(2'b10, 26'h0000055, 1'b0);
        push(2'b10, 26'h0000055, 1'b0);
        push(2'b01, 26'h0000056, 1'b0);
        check("t7_level", 32'(level), 32'd2);
        check("t7_coalesced", coalesced, 32'd1);
        do_clear();
        push(2'b01, 26'h0000077, 1'b0);
        push(2'b10, 26'h0000077, 1'b0);
        check("t7_upg_level", 32'(level), 32'd1);
        check("t7_upg_cmd", 32'(out_cmd), 32'h2);
        check("t7_upg_coalesced", coalesced, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
